// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//
// Contents:
//   uart_state_t   - transmit FSM states (IDLE, START, DATA, STOP)
//   REG_DATA       - offset of the DATA register from the block base address
//   REG_STATUS     - offset of the STATUS register from the block base address
//   STAT_*         - bit positions inside the STATUS byte
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam logic [15:0] REG_DATA   = 16'd0;
   localparam logic [15:0] REG_STATUS = 16'd1;

   localparam int STAT_OVERFLOW  = 7;
   localparam int STAT_TX_ACTIVE = 2;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_FULL      = 0;

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous circular FIFO feeding the UART transmitter.
//
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset (pointers only)
//   push, wdata - write request and its data
//   pop         - read request; rdata shows the head entry before the edge
//   rdata       - head of the FIFO (combinational read of registered storage)
//   full, empty - occupancy flags derived from the pointers
//
// Handshake: a push is taken at the clock edge when push=1 and either the
// FIFO is not full or a pop is taken on the same edge; a pop is taken when
// pop=1 and the FIFO is not empty. Requests that are not taken are ignored
// with no side effect, so the caller decides what a refused push means.
module mmio_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // One extra pointer bit distinguishes full from empty when the
   // index bits coincide.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign do_pop  = pop && !empty;
   // When full, a simultaneous pop frees the slot the push writes into.
   assign do_push = push && (!full || do_pop);

   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU 16-bit address / 8-bit data bus.
//
// Register map (relative to BASE_ADDR):
//   +0 DATA   write: queue one byte for transmission; read: 8'h00
//   +1 STATUS write: clear the sticky overflow flag;
//             read: {overflow, 4'b0, tx_active, fifo_empty, fifo_full}
//
// Ports:
//   clk, rst_n - system clock and synchronous active-low reset
//   addr       - CPU address {memory_bus_h, memory_bus_l}
//   wdata      - CPU store data
//   rW         - 1 = read, 0 = write
//   rdata      - OR-bus read data, 8'h00 unless a read hits DATA or STATUS
//   tx         - registered serial line, idles high
//   busy       - FIFO non-empty or a frame in flight
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR    = 16'hD000,
   parameter int          CLKS_PER_BIT = 104,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        rW,
   output logic [7:0]  rdata,
   output logic        tx,
   output logic        busy
);

   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   // ---------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------
   logic sel_data;
   logic sel_status;
   logic data_wr;
   logic status_wr;

   assign sel_data   = (addr == (BASE_ADDR + REG_DATA));
   assign sel_status = (addr == (BASE_ADDR + REG_STATUS));
   assign data_wr    = !rW && sel_data;
   assign status_wr  = !rW && sel_status;

   // ---------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------
   logic [7:0] fifo_rdata;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_pop;

   mmio_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (data_wr),
      .wdata (wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // ---------------------------------------------------------------
   // Transmit FSM: state register / next-state / outputs
   // ---------------------------------------------------------------
   uart_state_t   state;
   uart_state_t   state_next;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          bit_done;
   logic          tx_next;
   logic          tx_active;

   assign bit_done = (baud_cnt == BAUD_LAST);
   assign fifo_pop = (state == IDLE) && !fifo_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (!fifo_empty)                state_next = START;
         START: if (bit_done)                   state_next = DATA;
         DATA:  if (bit_done && bit_idx == 3'd7) state_next = STOP;
         STOP:  if (bit_done)                   state_next = IDLE;
         default:                               state_next = IDLE;
      endcase
   end

   always_comb begin
      tx_next   = 1'b1;
      tx_active = 1'b1;
      case (state)
         IDLE:    tx_active = 1'b0;
         START:   tx_next   = 1'b0;
         DATA:    tx_next   = shift_reg[0];
         STOP:    tx_next   = 1'b1;
         default: tx_active = 1'b0;
      endcase
   end

   // The line is a register copy of the FSM's view, one clock behind the
   // state; every bit keeps its full CLKS_PER_BIT width and tx is glitch-free.
   always_ff @(posedge clk) begin
      if (!rst_n) tx <= 1'b1;
      else        tx <= tx_next;
   end

   // Bit timing and data shifter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  shift_reg <= fifo_rdata;
                  baud_cnt  <= '0;
                  bit_idx   <= '0;
               end
            end
            DATA: begin
               if (bit_done) begin
                  baud_cnt  <= '0;
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  bit_idx   <= bit_idx + 3'd1;
               end else begin
                  baud_cnt  <= baud_cnt + {{(BW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               // START and STOP only time out one bit period.
               if (bit_done) baud_cnt <= '0;
               else          baud_cnt <= baud_cnt + {{(BW-1){1'b0}}, 1'b1};
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Sticky overflow: a refused store sets it; a STATUS store clears it.
   // A set on the same edge as a clear wins.
   // ---------------------------------------------------------------
   logic overflow;
   logic overflow_set;

   assign overflow_set = data_wr && fifo_full && !fifo_pop;

   always_ff @(posedge clk) begin
      if (!rst_n)            overflow <= 1'b0;
      else if (overflow_set) overflow <= 1'b1;
      else if (status_wr)    overflow <= 1'b0;
   end

   // ---------------------------------------------------------------
   // Read mux (OR-bus: zero when not selected) and busy
   // ---------------------------------------------------------------
   logic [7:0] status_word;

   always_comb begin
      status_word                 = 8'h00;
      status_word[STAT_OVERFLOW]  = overflow;
      status_word[STAT_TX_ACTIVE] = tx_active;
      status_word[STAT_EMPTY]     = fifo_empty;
      status_word[STAT_FULL]      = fifo_full;
   end

   always_comb begin
      rdata = 8'h00;
      if (rW && sel_status) rdata = status_word;
   end

   assign busy = tx_active || !fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A line monitor decodes every 8N1 frame and compares it against a queue
// of bytes that the stimulus tasks expect to be transmitted.
module tb_mmio_uart_tx;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam logic [15:0] BASE  = 16'hD000;
   localparam int          FRAME = 10 * CPB;

   // ---------------- clock / reset ----------------
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] addr  = 16'h0000;
   logic [7:0]  wdata = 8'h00;
   logic        rW    = 1'b1;
   logic [7:0]  rdata;
   logic        tx;
   logic        busy;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr),
      .wdata (wdata),
      .rW    (rW),
      .rdata (rdata),
      .tx    (tx),
      .busy  (busy)
   );

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         fall_q[$];
   bit         mon_en   = 1'b0;
   bit         mon_busy = 1'b0;
   logic [9:0] last_line = '0;
   int         last_wcyc = 0;

   // ---------------- line monitor ----------------
   initial begin
      logic       samp [FRAME];
      logic [9:0] line;
      logic [7:0] exp_b;
      bit         shape_ok;
      forever begin
         @(negedge clk);
         if (mon_en && tx === 1'b0) begin
            mon_busy = 1'b1;
            fall_q.push_back(cyc);
            for (int i = 0; i < FRAME; i++) begin
               if (i > 0) @(negedge clk);
               samp[i] = tx;
            end
            shape_ok = 1'b1;
            for (int k = 0; k < 10; k++) begin
               line[k] = samp[k*CPB];
               for (int j = 0; j < CPB; j++)
                  if (samp[k*CPB+j] !== samp[k*CPB]) shape_ok = 1'b0;
            end
            checks++;
            if (!shape_ok || line[0] !== 1'b0 || line[9] !== 1'b1) begin
               errors++;
               $display("FAIL frame_shape: line=%b stable=%0d, required start=0 stop=1 stable=1",
                        line, shape_ok);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame_data: unexpected frame byte=%h, required no frame", line[8:1]);
            end else begin
               exp_b = exp_q.pop_front();
               if (line[8:1] !== exp_b) begin
                  errors++;
                  $display("FAIL frame_data: got %h, required %h", line[8:1], exp_b);
               end
            end
            last_line = line;
            mon_busy  = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic r);
      @(negedge clk);
      addr  = a;
      wdata = d;
      rW    = r;
      @(posedge clk);
      #1;
      last_wcyc = cyc;
      addr  = 16'h0000;
      rW    = 1'b1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      bus_cycle(a, d, 1'b0);
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
      @(negedge clk);
      addr = a;
      rW   = 1'b1;
      #1;
      d    = rdata;
      addr = 16'h0000;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || mon_busy) begin
         errors++;
         $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles, required 0",
                  exp_q.size(), budget);
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   // Counts low samples on tx over n cycles.
   task automatic watch_idle(input int n, output int lows);
      lows = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] st;
      int         lows;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      bus_write(BASE, 8'h00);
      bus_write(BASE, 8'h11);
      bus_write(BASE, 8'h22);
      repeat (8) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset_tx: got %b, required 0 (mid-frame)", tx);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx_next_edge: got %b, required 1", tx);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b, required 0", busy);
      end
      bus_read(BASE + 16'd1, st);
      checks++;
      if (st !== 8'h02) begin
         errors++;
         $display("FAIL reset_status: got %h, required 02", st);
      end
      rst_n = 1'b1;
      watch_idle(60, lows);
      checks++;
      if (lows != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_discard: tx low %0d cycles busy=%b, required 0 and 0", lows, busy);
      end
   endtask

   task automatic test_single();
      logic [7:0] st;
      int         n;
      int         wc;
      mon_en = 1'b1;
      fall_q.delete();
      exp_q.push_back(8'hA5);
      bus_write(BASE, 8'hA5);
      wc = last_wcyc;
      n  = 0;
      while (fall_q.size() == 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (fall_q.size() == 0) begin
         errors++;
         $display("FAIL single_fall: no start bit within 20 cycles, required fall 2 cycles after store");
      end else if (fall_q[0] - wc != 2) begin
         errors++;
         $display("FAIL single_fall: fall %0d cycles after store, required 2", fall_q[0] - wc);
      end
      wait_drain(100);
      checks++;
      if (last_line !== 10'b1101001010) begin
         errors++;
         $display("FAIL single_line: got %b, required 1101001010 (LSB=start)", last_line);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_end: got %b, required 0", busy);
      end
      bus_read(BASE + 16'd1, st);
      checks++;
      if (st !== 8'h02) begin
         errors++;
         $display("FAIL single_status_end: got %h, required 02", st);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] st;
      logic [7:0] b;
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom_range(0, 255));
         if (i < 5) exp_q.push_back(b);
         bus_write(BASE, b);
      end
      bus_read(BASE + 16'd1, st);
      checks++;
      if (st !== 8'h85) begin
         errors++;
         $display("FAIL overflow_status: got %h, required 85", st);
      end
      bus_write(BASE + 16'd1, 8'hFF);
      bus_read(BASE + 16'd1, st);
      checks++;
      if (st !== 8'h05) begin
         errors++;
         $display("FAIL overflow_clear: got %h, required 05", st);
      end
      wait_drain(400);
      bus_read(BASE + 16'd1, st);
      checks++;
      if (st !== 8'h02) begin
         errors++;
         $display("FAIL overflow_idle_status: got %h, required 02", st);
      end
   endtask

   task automatic test_back_to_back();
      fall_q.delete();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      bus_write(BASE, 8'h00);
      bus_write(BASE, 8'hFF);
      wait_drain(200);
      checks++;
      if (fall_q.size() != 2) begin
         errors++;
         $display("FAIL b2b_frames: got %0d frames, required 2", fall_q.size());
      end else if (fall_q[1] - fall_q[0] != FRAME + 1) begin
         errors++;
         $display("FAIL b2b_gap: frame spacing %0d cycles, required %0d",
                  fall_q[1] - fall_q[0], FRAME + 1);
      end
   endtask

   task automatic test_decode();
      logic [7:0] st;
      int         lows;
      bus_read(BASE, st);
      checks++;
      if (st !== 8'h00) begin
         errors++;
         $display("FAIL decode_read_data: got %h, required 00", st);
      end
      bus_read(BASE + 16'd2, st);
      checks++;
      if (st !== 8'h00) begin
         errors++;
         $display("FAIL decode_read_d002: got %h, required 00", st);
      end
      bus_read(16'h5001, st);
      checks++;
      if (st !== 8'h00) begin
         errors++;
         $display("FAIL decode_read_alias: got %h, required 00", st);
      end
      bus_write(BASE + 16'd2, 8'h55);
      bus_cycle(BASE, 8'h55, 1'b1);
      watch_idle(50, lows);
      checks++;
      if (lows != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL decode_no_push: tx low %0d cycles busy=%b, required 0 and 0", lows, busy);
      end
      bus_read(BASE + 16'd1, st);
      checks++;
      if (st !== 8'h02) begin
         errors++;
         $display("FAIL decode_status: got %h, required 02", st);
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] st;
      logic [7:0] b;
      int         e1;
      int         n;
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         bus_write(BASE, b);
         if (i == 0) e1 = last_wcyc;
      end
      bus_read(BASE + 16'd1, st);
      checks++;
      if (st !== 8'h05) begin
         errors++;
         $display("FAIL fullpop_full: got %h, required 05", st);
      end
      // The first frame occupies the FSM for 10*CPB cycles starting one
      // edge after the first store; the IDLE pop edge is e1 + FRAME + 2.
      n = 0;
      while (cyc != e1 + FRAME + 1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      bus_write(BASE, b);
      bus_read(BASE + 16'd1, st);
      checks++;
      if (st !== 8'h05) begin
         errors++;
         $display("FAIL fullpop_accept: got %h, required 05 (no overflow, still full)", st);
      end
      wait_drain(400);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_back_to_back();
      test_decode();
      test_full_pop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
